// File: rtl/imm_gen_queue.sv
// Buffered RV32I/RV64I immediate generator: decodes the immediate at push and queues {imm, fmt, illegal}.
// Define IMMGEN_BRANCH_PC_ADJ_EN to emit B-format immediates pre-adjusted by -4.
module imm_gen_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head_d;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_d, rd_d;
    logic [CW-1:0]   count_d;
    logic            push, pop;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            s;
    logic [5:0]      shamt;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign s      = in_inst[31];
    assign shamt  = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

    // Immediate decode of the incoming word
    always_comb begin
        dec = '0;
        unique case (opcode)
            7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                dec.imm = sext32({{20{s}}, in_inst[31:20]});
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = XLEN'(shamt);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = sext32({{20{s}}, in_inst[31:20]});
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = sext32({{20{s}}, in_inst[31:25], in_inst[11:7]});
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
`ifdef IMMGEN_BRANCH_PC_ADJ_EN
                dec.imm = sext32({{19{s}}, s, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0})
                          - XLEN'(4);
`else
                dec.imm = sext32({{19{s}}, s, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
`endif
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = sext32({in_inst[31:12], 12'b0});
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = sext32({{11{s}}, s, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});
            end
            7'b0110011, 7'b1110011: begin
                dec.fmt = FMT_NONE;
            end
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Queue next state; the head register is preloaded with whatever will sit at rd_d
    always_comb begin
        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready && !flush;
        wr_d    = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_d    = pop  ? rd_ptr + PW'(1) : rd_ptr;
        count_d = out_count;
        if (push && !pop) count_d = out_count + CW'(1);
        if (pop && !push) count_d = out_count - CW'(1);
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
        head_d = (push && wr_ptr == rd_d) ? dec : mem[rd_d];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_count   <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
        end else begin
            wr_ptr    <= wr_d;
            rd_ptr    <= rd_d;
            out_count <= count_d;
            in_ready  <= (count_d != CW'(DEPTH));
            out_valid <= (count_d != '0);
            if (!flush && count_d != '0) begin
                out_imm     <= head_d.imm;
                out_fmt     <= head_d.fmt;
                out_illegal <= head_d.illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_queue.sv
// Directed self-checking bench for imm_gen_queue (XLEN=32/DEPTH=4 plus an XLEN=64/DEPTH=2 instance).
module tb_imm_gen_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [2:0]  out_count;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
    logic [31:0] in_inst64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [1:0]  out_count64;

    int passed = 0;
    int total  = 0;

`ifdef IMMGEN_BRANCH_PC_ADJ_EN
    localparam logic [63:0] BEQ_M4 = 64'hFFFF_FFFF_FFFF_FFF8;
`else
    localparam logic [63:0] BEQ_M4 = 64'hFFFF_FFFF_FFFF_FFFC;
`endif

    always #5 clk = ~clk;

    imm_gen_queue #(.XLEN(32), .DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_count(out_count)
    );

    imm_gen_queue #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_count(out_count64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Check the head of the 32-bit queue, then pop it
    task automatic expect_head(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                               input logic ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm"}, 64'(out_imm), 64'(imm));
        check({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
        pop_one();
    endtask

    task automatic expect_head64(input string tag, input logic [31:0] inst, input logic [63:0] imm,
                                 input logic [2:0] fmt);
        in_valid64 = 1'b1;
        in_inst64  = inst;
        tick();
        in_valid64 = 1'b0;
        check({tag, ".valid"}, 64'(out_valid64), 64'd1);
        check({tag, ".imm"}, out_imm64, imm);
        check({tag, ".fmt"}, 64'(out_fmt64), 64'(fmt));
        out_ready64 = 1'b1;
        tick();
        out_ready64 = 1'b0;
        check({tag, ".empty"}, 64'(out_count64), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; in_inst64 = '0;
        #23;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.count", 64'(out_count), 64'd0);
        check("rst.imm", 64'(out_imm), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single-entry decode cases, one push then pop each
        push_one(32'hFE000EE3);
        check("beq.count", 64'(out_count), 64'd1);
        expect_head("beq", BEQ_M4[31:0], 3'd3, 1'b0);
        check("beq.empty", 64'(out_valid), 64'd0);
        push_one(32'h123450B7); expect_head("lui",  32'h12345000, 3'd4, 1'b0);
        push_one(32'h008000EF); expect_head("jal",  32'h00000008, 3'd5, 1'b0);
        push_one(32'h00309093); expect_head("slli", 32'h00000003, 3'd6, 1'b0);
        push_one(32'h4030D093); expect_head("srai", 32'h00000003, 3'd6, 1'b0);
        push_one(32'h02309093); expect_head("slli_f7", 32'h00000003, 3'd6, 1'b0);
        push_one(32'h0000007F); expect_head("ill",  32'h00000000, 3'd7, 1'b1);
        push_one(32'hFFF00093); expect_head("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
        push_one(32'hFE20AC23); expect_head("sw",   32'hFFFFFFF8, 3'd2, 1'b0);
        push_one(32'h002081B3); expect_head("add",  32'h00000000, 3'd0, 1'b0);

        // Fill to DEPTH with the consumer stalled; fifth word must be held
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_inst = 32'h00000037 | (32'(i) << 12);
            tick();
        end
        check("full.count", 64'(out_count), 64'd4);
        check("full.in_ready", 64'(in_ready), 64'd0);
        in_inst = 32'h00005037;
        tick();
        check("held.count", 64'(out_count), 64'd4);
        check("held.in_ready", 64'(in_ready), 64'd0);
        check("held.head", 64'(out_imm), 64'h1000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop.count", 64'(out_count), 64'd3);
        check("pop.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("refill.count", 64'(out_count), 64'd4);
        expect_head("fifo2", 32'h00002000, 3'd4, 1'b0);
        expect_head("fifo3", 32'h00003000, 3'd4, 1'b0);
        expect_head("fifo4", 32'h00004000, 3'd4, 1'b0);
        expect_head("fifo5", 32'h00005000, 3'd4, 1'b0);
        check("drain.count", 64'(out_count), 64'd0);

        // Simultaneous push and pop at count 2
        push_one(32'h00001037);
        push_one(32'h00002037);
        in_valid = 1'b1; in_inst = 32'h00003037; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp.count", 64'(out_count), 64'd2);
        expect_head("pp1", 32'h00002000, 3'd4, 1'b0);
        expect_head("pp2", 32'h00003000, 3'd4, 1'b0);

        // Flush with a same-cycle push drops everything
        push_one(32'h00001037);
        push_one(32'h00002037);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00004037;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.count", 64'(out_count), 64'd0);
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        push_one(32'h00005037);
        check("postflush.count", 64'(out_count), 64'd1);
        expect_head("postflush", 32'h00005000, 3'd4, 1'b0);

        // Asynchronous reset mid-cycle with two entries queued
        push_one(32'h00001037);
        push_one(32'h00002037);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.count", 64'(out_count), 64'd0);
        #2;
        reset_n = 1'b1;
        tick();

        // XLEN=64 instance
        expect_head64("lui64",  32'h123450B7, 64'h0000_0000_1234_5000, 3'd4);
        expect_head64("addi64", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        expect_head64("slli64", 32'h02309093, 64'd35, 3'd6);
        expect_head64("beq64",  32'hFE000EE3, BEQ_M4, 3'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
